imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 127 ++++++++++++
 tb/tb_imem_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts a burst of 32-bit words over a valid/ready
// port and writes them byte-serially into a byte-addressed memory, with a combinational fetch port.
module imem_loader #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] word_count,
  input  logic        wr_valid,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data
);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] rem_q, rem_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic        mem_we;
  logic        in_range;

  logic [7:0]  mem [DEPTH];

  // Whole word must fit before any byte is written; 33 bits keeps the sum exact.
  assign in_range = ({1'b0, addr_q} + 33'd3) <= (33'(DEPTH) - 33'd1);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    bidx_d   = bidx_q;
    data_d   = data_q;
    err_d    = err_q;
    wr_ready = 1'b0;
    mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (word_count != 16'd0) begin
            state_d = ACCEPT;
            addr_d  = base_addr & ~32'h3;
            rem_d   = word_count;
            bidx_d  = 2'd0;
          end else begin
            state_d = DONE;
          end
        end
      end
      ACCEPT: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          if (in_range) begin
            data_d  = wr_data;
            bidx_d  = 2'd0;
            state_d = WRITE;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      WRITE: begin
        mem_we = 1'b1;
        bidx_d = bidx_q + 2'd1;
        if (bidx_q == 2'd3) begin
          addr_d  = addr_q + 32'd4;
          rem_d   = rem_q - 16'd1;
          state_d = (rem_q == 16'd1) ? DONE : ACCEPT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      bidx_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      bidx_q  <= bidx_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Memory is never reset; async reset drops the FSM to IDLE, which stops writes.
  logic [AW-1:0] waddr;
  assign waddr = AW'((addr_q + 32'(bidx_q)) % DEPTH);

  always_ff @(posedge clk) begin
    if (mem_we) mem[waddr] <= data_q[8*bidx_q +: 8];
  end

  logic [31:0]   ra;
  logic [AW-1:0] ra0, ra1, ra2, ra3;
  assign ra  = rd_addr % DEPTH;
  assign ra0 = AW'(ra);
  assign ra1 = AW'((ra + 32'd1) % DEPTH);
  assign ra2 = AW'((ra + 32'd2) % DEPTH);
  assign ra3 = AW'((ra + 32'd3) % DEPTH);
  assign rd_data = {mem[ra3], mem[ra2], mem[ra1], mem[ra0]};

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign err  = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: byte-array reference model of the memory,
// burst-level expectations for accept count, timing, err and done.
module tb_imem_loader;
  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst_n, start, wr_valid;
  logic [31:0] base_addr, wr_data, rd_addr, rd_data;
  logic [15:0] word_count;
  logic        wr_ready, busy, done, err;

  imem_loader #(.DEPTH(DEPTH), .AW(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .busy(busy), .done(done), .err(err),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0]  mm [DEPTH];
  logic        m_err = 1'b0;
  logic [31:0] fixed_q [$];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int b;
    b = int'(a % DEPTH);
    return {mm[(b+3)%DEPTH], mm[(b+2)%DEPTH], mm[(b+1)%DEPTH], mm[b]};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic burst(input logic [31:0] base, input int cnt, input int vprob,
                       input bit spam, input string nm);
    logic [31:0] sent [$];
    int          acc_cyc [$];
    int          c, exp_acc, exp_done;
    bit          got_done, exp_err, saw_ready;
    longint      a;
    a = longint'(base & 32'hFFFF_FFFC);
    exp_acc = 0; exp_err = 0;
    for (int i = 0; i < cnt; i++) begin
      exp_acc++;
      if (a + 3 > DEPTH - 1) begin exp_err = 1; break; end
      a += 4;
    end
    exp_done = exp_err ? 5*exp_acc - 3 : 1 + 5*cnt;

    start = 1; base_addr = base; word_count = cnt[15:0];
    tick(); start = 0; c = 1;
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL %s err_clear got=%b exp=0", nm, err); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL %s busy_after_start got=%b exp=1", nm, busy); end

    got_done = 0; saw_ready = 0;
    while (c < 200 + 40*cnt) begin
      if (done === 1'b1) begin got_done = 1; break; end
      if (spam && busy && ($urandom % 4 == 0)) begin
        start = 1; base_addr = $urandom; word_count = 16'($urandom);
      end
      if (wr_ready === 1'b1) begin
        saw_ready = 1;
        wr_valid = (($urandom % 100) < vprob);
        if (wr_valid) begin
          wr_data = (fixed_q.size() > 0) ? fixed_q.pop_front() : $urandom;
          sent.push_back(wr_data);
          acc_cyc.push_back(c);
        end
      end else begin
        wr_valid = 1'($urandom % 2);
        wr_data  = $urandom;
      end
      tick(); c++;
      wr_valid = 0; start = 0;
    end

    checks++;
    if (!got_done) begin failures++; $display("FAIL %s done_timeout cycles=%0d", nm, c); end
    checks++;
    if (sent.size() != exp_acc) begin
      failures++; $display("FAIL %s accept_count got=%0d exp=%0d", nm, sent.size(), exp_acc);
    end
    if (cnt == 0) begin
      checks++;
      if (saw_ready) begin failures++; $display("FAIL %s ready_on_zero got=1 exp=0", nm); end
    end
    if (vprob == 100) begin
      checks++;
      if (c != exp_done) begin failures++; $display("FAIL %s done_cycle got=%0d exp=%0d", nm, c, exp_done); end
      foreach (acc_cyc[k]) begin
        checks++;
        if (acc_cyc[k] != 1 + 5*k) begin
          failures++; $display("FAIL %s accept_cycle[%0d] got=%0d exp=%0d", nm, k, acc_cyc[k], 1 + 5*k);
        end
      end
    end

    m_err = 0;
    a = longint'(base & 32'hFFFF_FFFC);
    foreach (sent[k]) begin
      if (a + 3 <= DEPTH - 1) begin
        for (int j = 0; j < 4; j++) mm[int'(a) + j] = sent[k][8*j +: 8];
      end else m_err = 1;
      a += 4;
    end
    checks++;
    if (err !== m_err) begin failures++; $display("FAIL %s err_at_done got=%b exp=%b", nm, err, m_err); end

    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL %s done_one_cycle done=%b busy=%b exp=0,0", nm, done, busy);
    end
    checks++;
    if (err !== m_err) begin failures++; $display("FAIL %s err_sticky got=%b exp=%b", nm, err, m_err); end
  endtask

  task automatic check_mem(input string nm);
    logic [31:0] a;
    for (int i = 0; i < DEPTH/4; i++) begin
      rd_addr = 32'(i*4); #1;
      checks++;
      if (rd_data !== ref_rd(rd_addr)) begin
        failures++; $display("FAIL %s mem[%h] got=%h exp=%h", nm, rd_addr, rd_data, ref_rd(rd_addr));
      end
    end
    for (int i = 0; i < 32; i++) begin
      a = (i == 0) ? 32'h0000_0FFF : (i == 1) ? 32'hFFFF_FFFE : $urandom;
      rd_addr = a; #1;
      checks++;
      if (rd_data !== ref_rd(a)) begin
        failures++; $display("FAIL %s rd_unaligned[%h] got=%h exp=%h", nm, a, rd_data, ref_rd(a));
      end
    end
  endtask

  task automatic rd_expect(input logic [31:0] a, input logic [31:0] exp, input string nm);
    rd_addr = a; #1;
    checks++;
    if (rd_data !== exp) begin failures++; $display("FAIL %s got=%h exp=%h", nm, rd_data, exp); end
  endtask

  task automatic test_reset();
    rst_n = 0; start = 0; wr_valid = 0; wr_data = 0; base_addr = 0; word_count = 0; rd_addr = 0;
    #12;
    checks++;
    if (wr_ready !== 0 || busy !== 0 || done !== 0 || err !== 0) begin
      failures++; $display("FAIL reset_outputs ready=%b busy=%b done=%b err=%b exp=0000", wr_ready, busy, done, err);
    end
    rst_n = 1;
    tick();
    checks++;
    if (busy !== 0) begin failures++; $display("FAIL reset_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_preload();
    burst(32'h0, DEPTH/4, 100, 0, "preload");
    check_mem("preload");
  endtask

  task automatic test_back_to_back();
    fixed_q = '{32'h0000_0013, 32'hDEAD_BEEF};
    burst(32'h0, 2, 100, 0, "b2b");
    rd_expect(32'h4, 32'hDEAD_BEEF, "b2b_rd4");
    rd_expect(32'h0, 32'h0000_0013, "b2b_rd0");
    rd_addr = 32'h4; #1;
    checks++;
    if (rd_data[7:0] !== 8'hEF) begin failures++; $display("FAIL b2b_byte4 got=%h exp=ef", rd_data[7:0]); end
  endtask

  task automatic test_unaligned();
    fixed_q = '{32'h1122_3344};
    burst(32'h102, 1, 100, 0, "unaligned");
    rd_expect(32'h100, 32'h1122_3344, "unaligned_rd100");
  endtask

  task automatic test_out_of_range();
    burst(32'hFFC, 2, 100, 0, "oor_ffc");
    burst(32'h8000_0000, 3, 100, 0, "oor_high");
    burst(32'h10, 1, 100, 0, "oor_clear");
    check_mem("oor");
  endtask

  task automatic test_zero_count();
    burst(32'h40, 0, 100, 0, "zero");
    check_mem("zero");
  endtask

  task automatic test_reset_mid_write();
    start = 1; base_addr = 32'h20; word_count = 16'd2;
    tick(); start = 0;
    wr_valid = 1; wr_data = 32'hAABB_CCDD;
    tick(); wr_valid = 0;
    tick(); tick();
    rst_n = 0; #1;
    mm[32'h20] = 8'hDD; mm[32'h21] = 8'hCC;
    checks++;
    if (wr_ready !== 0 || busy !== 0 || done !== 0 || err !== 0) begin
      failures++; $display("FAIL midrst_outputs ready=%b busy=%b done=%b err=%b exp=0000", wr_ready, busy, done, err);
    end
    rd_expect(32'h20, ref_rd(32'h20), "midrst_rd_in_reset");
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (done !== 0 || busy !== 0) begin failures++; $display("FAIL midrst_hold done=%b busy=%b exp=0,0", done, busy); end
    end
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (done !== 0 || busy !== 0) begin failures++; $display("FAIL midrst_after done=%b busy=%b exp=0,0", done, busy); end
    end
    check_mem("midrst");
  endtask

  task automatic test_random();
    logic [31:0] b;
    for (int n = 0; n < 30; n++) begin
      b = ($urandom % 8 == 0) ? $urandom : 32'($urandom % DEPTH);
      burst(b, 1 + int'($urandom % 8), 50, 1, "random");
    end
    check_mem("random");
  endtask

  initial begin
    test_reset();
    test_preload();
    test_back_to_back();
    test_unaligned();
    test_out_of_range();
    test_zero_count();
    test_reset_mid_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
